serial_bitstream_piso: RTL and testbench
========================================

# serial_bitstream_piso

Parallel-in/serial-out stage that feeds the Mealy 1010 overlapping sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and drives them MSB-first, one bit per clock, onto a registered serial line that connects directly to the detector's serial input. Back-to-back words stream with no idle bubble, so patterns spanning a word boundary stay detectable.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low: 0 = reset.
- data_in  input  WIDTH  parallel word; sampled only on an accept edge.
- valid_in  input  1  upstream has a word on data_in.
- ready_out  output  1  block can accept a word this cycle. Combinational from state.
- ser_out  output  1  serial bit, registered; goes to the detector input.
- ser_valid  output  1  ser_out carries a frame bit this cycle; registered.
- frame_done  output  1  one-cycle pulse, registered; high while the final bit of a frame is on ser_out.

## Operation
- Accept: `valid_in && ready_out` at a rising edge.
- States:
  - IDLE
  - SHIFT
  - PAR (exists only with SER_PARITY_EN).
- Internal state: shift register `shreg[WIDTH-1:0]` and bit counter `cnt`, width `$clog2(WIDTH)+1`.
- IDLE:
  - ready_out=1, ser_valid=0, ser_out=0.
  - On accept: `ser_out<=data_in[WIDTH-1]`, `shreg<=data_in<<1`, `cnt<=1`, `ser_valid<=1`, go to SHIFT.
- SHIFT, when `cnt<WIDTH`: `ser_out<=shreg[WIDTH-1]`, `shreg<=shreg<<1`, `cnt<=cnt+1`.
- Last data bit: the SHIFT cycle in which `cnt==WIDTH`. frame_done=1 in that cycle when no PAR state exists.
- Frame end, without SER_PARITY_EN:
  - ready_out=1 in the last-bit cycle.
  - On accept at that edge: load the new word exactly as from IDLE and stay in SHIFT. The stream is contiguous and ser_valid stays 1.
  - With no accept: go to IDLE, and ser_valid and ser_out drop to 0.
- Frame end, with SER_PARITY_EN: see Configuration.
- ready_out=0 in all other SHIFT cycles. valid_in is ignored there and data_in is not sampled.
- Upstream must hold valid_in and data_in stable until accepted. The block does not check this.
- Async reset mid-frame: the in-flight word is dropped with no partial completion. After rst releases, the block is in IDLE.

## Timing
- Reset values:
  - state=IDLE, shreg=0, cnt=0.
  - ser_out=0, ser_valid=0, frame_done=0.
  - ready_out=1 as soon as rst=0; no clock edge needed.
- Latency: the MSB appears on ser_out in the cycle following the accept edge.
- Frame length: WIDTH cycles of ser_valid=1, or WIDTH+1 with parity.
- Throughput: one word per WIDTH cycles (WIDTH+1 with parity) under continuous valid_in.
- Simultaneous frame end and accept: the new MSB follows the last bit on the very next cycle, with no gap.
- Reset: rst is sampled asynchronously. Release is synchronous to clk and must meet recovery timing.

## Configuration
- SER_PARITY_EN defined:
  - After the last data bit, the block enters PAR for one cycle.
  - In PAR, ser_out = even parity: the XOR of the frame's data bits, so the total count of ones is even. ser_valid=1.
  - frame_done and ready_out move to the PAR cycle. They are 0 in the last data-bit cycle.
  - An accept in PAR behaves like an accept in the last-bit cycle without parity. A parity accumulator register is added.
- SER_PARITY_EN undefined: the PAR state and the parity logic are absent. Behaviour is as described in Operation.

## Test plan
- Reset: hold rst=0 with random inputs.
  - Required: ser_out=0, ser_valid=0, frame_done=0, ready_out=1.
  - After release with valid_in=0: no change for 20 cycles.
- Single word, WIDTH=8: data_in=8'hA5 accepted at edge E0.
  - Required: ser_out = 1,0,1,0,0,1,0,1 in cycles E0+1..E0+8.
  - Required: frame_done only in cycle E0+8; ser_valid=0 from E0+9.
- Back-to-back: valid_in held with 8'hAA then 8'h0A.
  - Required: 16 contiguous ser_valid cycles, stream 10101010 00001010.
  - Required: ready_out high only in cycle 8 and cycle 16.
  - Downstream detector: out pulses at the expected overlapping positions.
- Mid-frame valid: assert valid_in with 8'hFF during bit 3 of a frame.
  - Required: not accepted until the last-bit cycle; the current frame is unchanged.
- Reset mid-operation: drive rst=0 during bit 4 of 8'hC3.
  - Required: ser_valid=0 and ser_out=0 immediately, without waiting for an edge.
  - After release: the next accepted word serializes from its MSB.
- Parity (SER_PARITY_EN):
  - 8'h07 → 8 data bits, then parity bit 1 in cycle E0+9, with frame_done in that cycle.
  - 8'h03 → parity bit 0.

Source files
------------

// File: rtl/serial_bitstream_piso_if.sv
// rtl/serial_bitstream_piso_if.sv - word handshake between upstream source and the serializer
interface serial_bitstream_piso_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out
    );
endinterface

// File: rtl/serial_bitstream_piso.sv
// rtl/serial_bitstream_piso.sv - MSB-first parallel-in/serial-out feeder for the 1010 detector
// Optional trailing even-parity bit per frame: define SER_PARITY_EN.
module serial_bitstream_piso #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_bitstream_piso_if.slave up,
    output logic                   ser_out,
    output logic                   ser_valid,
    output logic                   frame_done
);
    localparam int              CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             ready;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Next-state and next-output logic; an accept overrides the end-of-frame fallthrough
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        ser_out_d    = 1'b0;
        ser_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        ready        = 1'b0;
`ifdef SER_PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            IDLE: begin
                ready = 1'b1;
            end
            SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    ser_out_d   = shreg_q[WIDTH-1];
                    shreg_d     = shreg_q << 1;
                    cnt_d       = cnt_q + CNT_ONE;
                    ser_valid_d = 1'b1;
`ifndef SER_PARITY_EN
                    frame_done_d = ((cnt_q + CNT_ONE) == CNT_LAST);
`endif
                end else begin
`ifdef SER_PARITY_EN
                    // Last data bit on the line: the parity bit follows it
                    state_d      = PAR;
                    cnt_d        = '0;
                    ser_out_d    = par_q;
                    ser_valid_d  = 1'b1;
                    frame_done_d = 1'b1;
`else
                    ready   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PAR: begin
                ready   = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        accept = up.valid_in && ready;
        if (accept) begin
            state_d      = SHIFT;
            ser_out_d    = up.data_in[WIDTH-1];
            shreg_d      = up.data_in << 1;
            cnt_d        = CNT_ONE;
            ser_valid_d  = 1'b1;
            frame_done_d = 1'b0;
`ifdef SER_PARITY_EN
            par_d        = ^up.data_in;
`endif
        end
    end

    // State and registered serial outputs; reset drops any in-flight word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            ser_out_q    <= 1'b0;
            ser_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            ser_out_q    <= ser_out_d;
            ser_valid_q  <= ser_valid_d;
            frame_done_q <= frame_done_d;
`ifdef SER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    assign up.ready_out = ready;
    assign ser_out      = ser_out_q;
    assign ser_valid    = ser_valid_q;
    assign frame_done   = frame_done_q;
endmodule

// File: tb/tb_serial_bitstream_piso.sv
// tb/tb_serial_bitstream_piso.sv - directed self-checking bench for serial_bitstream_piso
module tb_serial_bitstream_piso;
    localparam int WIDTH = 8;
`ifdef SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FLEN = WIDTH + P;

    logic clk = 1'b0;
    logic rst;
    logic ser_out, ser_valid, frame_done;
    int   n_vec = 0;
    int   n_err = 0;

    serial_bitstream_piso_if #(.WIDTH(WIDTH)) bus ();

    serial_bitstream_piso #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .up         (bus.slave),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst          = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        #2;
        for (int i = 0; i < 5; i++) begin
            bus.data_in  = 8'($urandom);
            bus.valid_in = 1'($urandom_range(0, 1));
            tick;
            n_vec++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL reset_ser_out: got %b want 0", ser_out); end
            n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid); end
            n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
            n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
        end
        bus.valid_in = 1'b0;
        rst          = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            n_vec++; if (ser_valid !== 1'b0 || ser_out !== 1'b0 || frame_done !== 1'b0 || bus.ready_out !== 1'b1) begin
                n_err++;
                $display("FAIL post_reset_idle cyc%0d: got valid=%b out=%b done=%b ready=%b want 0 0 0 1",
                         i, ser_valid, ser_out, frame_done, bus.ready_out);
            end
        end
    endtask

    task automatic test_single;
        logic [7:0] w;
        logic       exp_bit, exp_fd;
        w            = 8'hA5;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL single_ready_idle: got %b want 1", bus.ready_out); end
        tick;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        for (int k = 1; k <= FLEN; k++) begin
            exp_bit = (k <= WIDTH) ? w[WIDTH-k] : ^w;
            exp_fd  = (k == FLEN);
            n_vec++; if (ser_out !== exp_bit) begin n_err++; $display("FAIL single_bit cyc%0d: got %b want %b", k, ser_out, exp_bit); end
            n_vec++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL single_valid cyc%0d: got %b want 1", k, ser_valid); end
            n_vec++; if (frame_done !== exp_fd) begin n_err++; $display("FAIL single_done cyc%0d: got %b want %b", k, frame_done, exp_fd); end
            n_vec++; if (bus.ready_out !== exp_fd) begin n_err++; $display("FAIL single_ready cyc%0d: got %b want %b", k, bus.ready_out, exp_fd); end
            tick;
        end
        for (int k = 0; k < 2; k++) begin
            n_vec++; if (ser_valid !== 1'b0 || ser_out !== 1'b0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL single_after: got valid=%b out=%b done=%b want 0 0 0", ser_valid, ser_out, frame_done);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [17:0] exp_stream;
        logic [17:0] exp_det;
        int          n;
        int          ds;
        logic        det, b, exp_rdy;
`ifdef SER_PARITY_EN
        exp_stream = 18'b10101010_0_00001010_0;
        exp_det    = 18'b000101010_000000010;
`else
        exp_stream = {2'b00, 16'b10101010_00001010};
        exp_det    = {2'b00, 16'b00010101_00000001};
`endif
        n  = 2 * FLEN;
        ds = 0;
        bus.data_in  = 8'hAA;
        bus.valid_in = 1'b1;
        tick;
        bus.data_in  = 8'h0A;
        for (int i = 1; i <= n; i++) begin
            b       = ser_out;
            exp_rdy = (i == FLEN) || (i == n);
            n_vec++; if (ser_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid cyc%0d: got %b want 1", i, ser_valid); end
            n_vec++; if (b !== exp_stream[n-i]) begin n_err++; $display("FAIL b2b_bit cyc%0d: got %b want %b", i, b, exp_stream[n-i]); end
            n_vec++; if (bus.ready_out !== exp_rdy) begin n_err++; $display("FAIL b2b_ready cyc%0d: got %b want %b", i, bus.ready_out, exp_rdy); end
            det = 1'b0;
            case (ds)
                0: ds = b ? 1 : 0;
                1: ds = b ? 1 : 2;
                2: ds = b ? 3 : 0;
                default: begin det = !b; ds = b ? 1 : 2; end
            endcase
            n_vec++; if (det !== exp_det[n-i]) begin n_err++; $display("FAIL b2b_detect cyc%0d: got %b want %b", i, det, exp_det[n-i]); end
            tick;
            if (i == FLEN) bus.valid_in = 1'b0;
        end
        n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end_valid: got %b want 0", ser_valid); end
        tick;
    endtask

    task automatic test_mid_valid;
        logic [7:0] w;
        logic       exp_bit, exp_rdy;
        w            = 8'h3C;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        tick;
        bus.valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            if (i == 3) begin
                bus.data_in  = 8'hFF;
                bus.valid_in = 1'b1;
            end
            exp_bit = (i <= WIDTH) ? w[WIDTH-i] : ^w;
            exp_rdy = (i == FLEN);
            n_vec++; if (ser_out !== exp_bit) begin n_err++; $display("FAIL mid_bit cyc%0d: got %b want %b", i, ser_out, exp_bit); end
            n_vec++; if (bus.ready_out !== exp_rdy) begin n_err++; $display("FAIL mid_ready cyc%0d: got %b want %b", i, bus.ready_out, exp_rdy); end
            tick;
        end
        bus.valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            exp_bit = (i <= WIDTH) ? 1'b1 : 1'b0;
            n_vec++; if (ser_out !== exp_bit || ser_valid !== 1'b1) begin
                n_err++;
                $display("FAIL mid_next cyc%0d: got out=%b valid=%b want %b 1", i, ser_out, ser_valid, exp_bit);
            end
            tick;
        end
        n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL mid_end_valid: got %b want 0", ser_valid); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] w;
        logic       exp_bit;
        w            = 8'hC3;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        tick;
        bus.valid_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_vec++; if (ser_out !== w[WIDTH-i]) begin n_err++; $display("FAIL rmid_bit cyc%0d: got %b want %b", i, ser_out, w[WIDTH-i]); end
            if (i < 4) tick;
        end
        #2;
        rst = 1'b0;
        #1;
        n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async_valid: got %b want 0", ser_valid); end
        n_vec++; if (ser_out !== 1'b0) begin n_err++; $display("FAIL rmid_async_out: got %b want 0", ser_out); end
        n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL rmid_async_ready: got %b want 1", bus.ready_out); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick;
        n_vec++; if (ser_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_released: got valid=%b done=%b want 0 0", ser_valid, frame_done);
        end
        w            = 8'h5A;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        tick;
        bus.valid_in = 1'b0;
        for (int i = 1; i <= FLEN; i++) begin
            exp_bit = (i <= WIDTH) ? w[WIDTH-i] : ^w;
            n_vec++; if (ser_out !== exp_bit || ser_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rmid_new cyc%0d: got out=%b valid=%b want %b 1", i, ser_out, ser_valid, exp_bit);
            end
            tick;
        end
        n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL rmid_end_valid: got %b want 0", ser_valid); end
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity;
        logic [7:0] words [2];
        logic       pbits [2];
        words[0] = 8'h07; pbits[0] = 1'b1;
        words[1] = 8'h03; pbits[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            bus.data_in  = words[t];
            bus.valid_in = 1'b1;
            tick;
            bus.valid_in = 1'b0;
            for (int i = 1; i <= WIDTH; i++) begin
                n_vec++; if (ser_out !== words[t][WIDTH-i] || frame_done !== 1'b0 || bus.ready_out !== 1'b0) begin
                    n_err++;
                    $display("FAIL par_data w%0d cyc%0d: got out=%b done=%b ready=%b want %b 0 0",
                             t, i, ser_out, frame_done, bus.ready_out, words[t][WIDTH-i]);
                end
                tick;
            end
            n_vec++; if (ser_out !== pbits[t]) begin n_err++; $display("FAIL par_bit w%0d: got %b want %b", t, ser_out, pbits[t]); end
            n_vec++; if (frame_done !== 1'b1 || ser_valid !== 1'b1 || bus.ready_out !== 1'b1) begin
                n_err++;
                $display("FAIL par_cycle w%0d: got done=%b valid=%b ready=%b want 1 1 1", t, frame_done, ser_valid, bus.ready_out);
            end
            tick;
            n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL par_end w%0d: got %b want 0", t, ser_valid); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_mid_valid;
        test_reset_mid;
`ifdef SER_PARITY_EN
        test_parity;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
